dmem_responder: RTL and testbench

Handshaked data-memory responder that sits on the target side of the core's load/store port, replacing the zero-latency combinational data memory. It accepts one word-sized read or write request at a time, performs the access on the accept edge, then delays the response by a programmable number of wait states to model slower memory. It flags misaligned and out-of-range accesses. Multi-cycle core variants use it as their data memory.

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 110 +++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and address-split constants for the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

    // Byte address = {word index, byte offset}.
    localparam int unsigned OffsetLsb  = 0;
    localparam int unsigned OffsetMsb  = $clog2(WORD_BYTES) - 1;
    localparam int unsigned WordIdxLsb = OffsetMsb + 1;
    localparam int unsigned WordIdxMsb = 31;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, word i powers up as i.
module dmem_array #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AddrW = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] words [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        // Power-up value only; reset deliberately leaves the contents alone.
        logic [31:0] word_q = 32'(i);

        // Commit a store addressed to this word.
        always_ff @(posedge clk) begin
            if (we && (waddr == AddrW'(i))) begin
                word_q <= wdata;
            end
        end

        assign words[i] = word_q;
    end

    assign rdata = words[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one access, performs it on the accept edge,
// then holds the response back for WAIT_CYCLES cycles before presenting it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic             addr_err;
    logic             mem_we;
    logic [AddrW-1:0] word_idx;
    logic [31:0]      mem_rdata;

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign word_idx = req_addr[WordIdxLsb +: AddrW];
    assign addr_err = (req_addr[OffsetMsb:OffsetLsb] != '0) ||
                      ({{WordIdxLsb{1'b0}}, req_addr[WordIdxMsb:WordIdxLsb]} >= DEPTH);

    // Reset wins over a same-cycle request, so the store is gated by rst as well.
    assign mem_we = req_valid && req_ready && req_write && !addr_err && !rst;

    dmem_array #(
        .DEPTH (DEPTH),
        .AddrW (AddrW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_idx),
        .wdata (req_wdata),
        .raddr (word_idx),
        .rdata (mem_rdata)
    );

    // Next-state logic: capture the response on accept, count wait states, release on handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rdata_d = (req_write || addr_err) ? 32'h0 : mem_rdata;
                    err_d   = addr_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: vector table on a WAIT_CYCLES=2 instance, hand sequences for
// backpressure, reset and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WAIT_CYCLES = 2 instance
    logic        rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    // WAIT_CYCLES = 0 instance
    logic        rst0, req_valid0, req_ready0, req_write0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

    dmem_responder #(
        .DEPTH       (128),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(
        .DEPTH       (128),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst0),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_write (req_write0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NumVecs = 12;
    vec_t vecs [NumVecs];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts just after a clock edge with the WAIT_CYCLES=2 instance idle.
    task automatic txn(input string name, input vec_t v);
        int   lat;
        logic ready_seen;
        check({name, "/ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_write  = 1'b1;
        req_addr   = 32'h0000_0000;
        req_wdata  = 32'hBAD0_BAD0;
        lat        = 0;
        ready_seen = req_ready;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            ready_seen = ready_seen | req_ready;
        end
        check({name, "/latency"}, 32'(lat), 32'd2);
        check({name, "/ready_low"}, 32'(ready_seen), 32'd0);
        check({name, "/rdata"}, rsp_rdata, v.exp_rdata);
        check({name, "/err"}, 32'(rsp_err), 32'(v.exp_err));
        @(posedge clk); #1;
        check({name, "/valid_after"}, 32'(rsp_valid), 32'd0);
        check({name, "/ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0004, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1};
        vecs[4]  = '{1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,         1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h0000_01FC, 32'h0,         32'h0000_007F, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_01FC, 32'hA5A5_5A5A, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h0000_01FC, 32'h0,         32'hA5A5_5A5A, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0001, 1'b0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        rst0 = 1'b1; req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
        rsp_ready0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst0 = 1'b0;

        check("reset/req_ready", 32'(req_ready), 32'd1);
        check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset/rsp_rdata", rsp_rdata, 32'h0);
        check("reset/rsp_err", 32'(rsp_err), 32'd0);
        check("reset0/req_ready", 32'(req_ready0), 32'd1);
        check("reset0/rsp_valid", 32'(rsp_valid0), 32'd0);

        for (int i = 0; i < NumVecs; i++) begin
            txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: load 0x10 and hold the response for 5 cycles under a pending request.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
        @(posedge clk); #1;
        req_addr = 32'h0000_0020; req_write = 1'b1; req_wdata = 32'h1111_2222;
        for (int n = 0; n < 20 && !rsp_valid; n++) begin
            @(posedge clk); #1;
        end
        for (int c = 0; c < 5; c++) begin
            check("bp/rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp/rsp_rdata", rsp_rdata, 32'h0000_0004);
            check("bp/rsp_err", 32'(rsp_err), 32'd0);
            check("bp/req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp/valid_after", 32'(rsp_valid), 32'd0);
        check("bp/ready_after", 32'(req_ready), 32'd1);
        txn("bp_noaccept", '{1'b0, 32'h0000_0020, 32'h0, 32'h0000_0008, 1'b0});

        // Reset during WAIT after a store of 0x55 to word 0.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid/in_wait", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid/req_ready", 32'(req_ready), 32'd1);
        check("rstmid/rsp_err", 32'(rsp_err), 32'd0);
        // Reset together with a request: nothing is accepted or written.
        rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h0000_0099;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        check("rstreq/req_ready", 32'(req_ready), 32'd1);
        check("rstreq/rsp_valid", 32'(rsp_valid), 32'd0);
        txn("rst_readback", '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0055, 1'b0});

        // WAIT_CYCLES=0: back-to-back loads of 0x4 then 0xC, accepts two cycles apart.
        rsp_ready0 = 1'b1;
        req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h0000_0004;
        check("w0/ready_c0", 32'(req_ready0), 32'd1);
        @(posedge clk); #1;
        check("w0/valid_c1", 32'(rsp_valid0), 32'd1);
        check("w0/rdata_c1", rsp_rdata0, 32'h0000_0001);
        check("w0/ready_c1", 32'(req_ready0), 32'd0);
        req_addr0 = 32'h0000_000C;
        @(posedge clk); #1;
        check("w0/valid_c2", 32'(rsp_valid0), 32'd0);
        check("w0/ready_c2", 32'(req_ready0), 32'd1);
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        check("w0/valid_c3", 32'(rsp_valid0), 32'd1);
        check("w0/rdata_c3", rsp_rdata0, 32'h0000_0003);
        check("w0/err_c3", 32'(rsp_err0), 32'd0);
        @(posedge clk); #1;
        check("w0/valid_c4", 32'(rsp_valid0), 32'd0);
        check("w0/ready_c4", 32'(req_ready0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
